// File: rtl/systolic_array_pkg.sv
// systolic_array_pkg: phase codes shared by the sequencer and the array controller.
// Holds CTRL_WIDTH and the phase_t encoding IDLE/WARMUP/STEADY/DRAIN.
package systolic_array_pkg;

  localparam int CTRL_WIDTH = 4;

  typedef enum logic [CTRL_WIDTH-1:0] {
    PH_IDLE   = 4'd0,
    PH_WARMUP = 4'd1,
    PH_STEADY = 4'd2,
    PH_DRAIN  = 4'd3
  } phase_t;

endpackage

// File: rtl/systolic_array_phase_counter.sv
// systolic_array_phase_counter: loadable down-counter that stops at 1.
// Ports: clk, rst_n, i_load/i_load_val (load wins), i_en (decrement), o_term (count==1).
module systolic_array_phase_counter #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_term
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count > WIDTH'(1))) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_term = (r_count == WIDTH'(1));

endmodule

// File: rtl/systolic_array_sequencer.sv
// systolic_array_sequencer: steps one tile through IDLE, WARMUP, STEADY, DRAIN.
// Ports: clk, rst_n, i_start, i_abort, SRAM read windows, i_sa_datapath_valid_down;
// outputs o_ctrl_state, o_busy, o_done, o_err (all registered).
// Optional macro SYSTOLIC_ARRAY_SEQ_DRAIN_TIMEOUT_EN adds a DRAIN watchdog.
module systolic_array_sequencer
  import systolic_array_pkg::*;
#(
  parameter int NUM_ROW              = 8,
  parameter int NUM_COL              = 8,
  parameter int LOG2_SRAM_BANK_DEPTH = 10,
  parameter int SKEW_LEFT_INPUT_EN   = 1,
  parameter int WARMUP_PAD           = 3,
  parameter int DRAIN_QUIET          = 4,
  parameter int DRAIN_TIMEOUT        = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_start,
  input  logic                            i_abort,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_sram_rd_start_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_sram_rd_end_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_sram_rd_start_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_sram_rd_end_addr,
  input  logic [NUM_COL-1:0]              i_sa_datapath_valid_down,
  output logic [CTRL_WIDTH-1:0]           o_ctrl_state,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_err
);

  localparam int CW = LOG2_SRAM_BANK_DEPTH + 1;
  localparam int QW = $clog2(DRAIN_QUIET + 1);
  localparam logic [CW-1:0] SKEW_CYC =
    (SKEW_LEFT_INPUT_EN != 0) ? CW'(NUM_ROW + NUM_COL - 2) : '0;

  phase_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [CW-1:0] r_left_len;
  logic [QW-1:0] r_quiet;

  logic [CW-1:0] w_top_len;
  logic [CW-1:0] w_left_len;
  logic [CW-1:0] w_load_val;
  logic          w_win_ok;
  logic          w_load;
  logic          w_en;
  logic          w_term;
  logic [QW-1:0] w_quiet_nxt;
  logic          w_quiet_hit;
  logic          w_timeout;

  // Extra bit keeps a full-depth window (1024) from wrapping.
  assign w_top_len  = {1'b0, i_top_sram_rd_end_addr}
                    - {1'b0, i_top_sram_rd_start_addr} + CW'(1);
  assign w_left_len = {1'b0, i_left_sram_rd_end_addr}
                    - {1'b0, i_left_sram_rd_start_addr} + CW'(1);
  assign w_win_ok =
    (i_top_sram_rd_end_addr >= i_top_sram_rd_start_addr) &&
    (i_left_sram_rd_end_addr >= i_left_sram_rd_start_addr);

  // One counter serves both phases: loaded on accept, reloaded at WARMUP end.
  assign w_load = ((r_state == PH_IDLE) && i_start && w_win_ok) ||
                  ((r_state == PH_WARMUP) && w_term);
  assign w_load_val = (r_state == PH_IDLE) ?
                      w_top_len + CW'(WARMUP_PAD) :
                      r_left_len + SKEW_CYC;
  assign w_en = (r_state == PH_WARMUP) || (r_state == PH_STEADY);

  systolic_array_phase_counter #(
    .WIDTH(CW)
  ) u_phase_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .i_en      (w_en),
    .o_term    (w_term)
  );

  assign w_quiet_nxt = (|i_sa_datapath_valid_down) ? '0 : r_quiet + QW'(1);
  assign w_quiet_hit = (w_quiet_nxt == QW'(DRAIN_QUIET));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_quiet <= '0;
    else        r_quiet <= (r_state == PH_DRAIN) ? w_quiet_nxt : '0;
  end

`ifdef SYSTOLIC_ARRAY_SEQ_DRAIN_TIMEOUT_EN
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
  logic [DW-1:0] r_age;
  logic [DW-1:0] w_age_nxt;

  assign w_age_nxt = r_age + DW'(1);
  assign w_timeout = (w_age_nxt == DW'(DRAIN_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_age <= '0;
    else        r_age <= (r_state == PH_DRAIN) ? w_age_nxt : '0;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= PH_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_left_len <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        PH_IDLE: begin
          if (i_start && w_win_ok) begin
            r_state    <= PH_WARMUP;
            r_busy     <= 1'b1;
            r_left_len <= w_left_len;
          end else if (i_start) begin
            r_err <= 1'b1;
          end
        end
        PH_WARMUP: begin
          if (i_abort) begin
            r_state <= PH_IDLE;
            r_busy  <= 1'b0;
          end else if (w_term) begin
            r_state <= PH_STEADY;
          end
        end
        PH_STEADY: begin
          if (i_abort) begin
            r_state <= PH_IDLE;
            r_busy  <= 1'b0;
          end else if (w_term) begin
            r_state <= PH_DRAIN;
          end
        end
        PH_DRAIN: begin
          if (i_abort) begin
            r_state <= PH_IDLE;
            r_busy  <= 1'b0;
          end else if (w_quiet_hit) begin
            r_state <= PH_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_timeout) begin
            r_state <= PH_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end
        end
        default: begin
          r_state <= PH_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ctrl_state = r_state;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// tb_systolic_array_sequencer: vector table, directed corner sequences and
// random traffic checked against a phase-duration reference model.
module tb_systolic_array_sequencer;

  localparam int AW    = 10;
  localparam int NC    = 8;
  localparam int NR    = 8;
  localparam int PAD   = 3;
  localparam int QUIET = 4;
  localparam int TO    = 64;
  localparam int SKEW  = NR + NC - 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] ts = '0, te = '0, ls = '0, le = '0;
  logic [NC-1:0] vd = '0;
  logic [3:0]    st;
  logic          busy, done, err;
  logic [3:0]    ns_st;
  logic          ns_busy, ns_done, ns_err;

  systolic_array_sequencer #(
    .NUM_ROW(NR), .NUM_COL(NC), .LOG2_SRAM_BANK_DEPTH(AW),
    .SKEW_LEFT_INPUT_EN(1), .WARMUP_PAD(PAD),
    .DRAIN_QUIET(QUIET), .DRAIN_TIMEOUT(TO)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_top_sram_rd_start_addr(ts), .i_top_sram_rd_end_addr(te),
    .i_left_sram_rd_start_addr(ls), .i_left_sram_rd_end_addr(le),
    .i_sa_datapath_valid_down(vd),
    .o_ctrl_state(st), .o_busy(busy), .o_done(done), .o_err(err)
  );

  // Same inputs, no left-edge skew.
  systolic_array_sequencer #(
    .NUM_ROW(NR), .NUM_COL(NC), .LOG2_SRAM_BANK_DEPTH(AW),
    .SKEW_LEFT_INPUT_EN(0), .WARMUP_PAD(PAD),
    .DRAIN_QUIET(QUIET), .DRAIN_TIMEOUT(TO)
  ) u_dut_ns (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_top_sram_rd_start_addr(ts), .i_top_sram_rd_end_addr(te),
    .i_left_sram_rd_start_addr(ls), .i_left_sram_rd_end_addr(le),
    .i_sa_datapath_valid_down(vd),
    .o_ctrl_state(ns_st), .o_busy(ns_busy), .o_done(ns_done), .o_err(ns_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: current phase plus cycles left in it.
  int m_ph = 0, m_rem = 0, m_next = 0, m_quiet = 0, m_age = 0;
  bit m_done = 0, m_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_rem = 0; m_next = 0; m_quiet = 0; m_age = 0;
    m_done = 0; m_err = 0;
  endtask

  task automatic model_edge();
    m_done = 0;
    m_err  = 0;
    case (m_ph)
      0: if (start) begin
        if (te >= ts && le >= ls) begin
          m_ph   = 1;
          m_rem  = int'(te) - int'(ts) + 1 + PAD;
          m_next = int'(le) - int'(ls) + 1 + SKEW;
        end else begin
          m_err = 1;
        end
      end
      1: if (abort) m_ph = 0;
         else begin
           m_rem--;
           if (m_rem == 0) begin m_ph = 2; m_rem = m_next; end
         end
      2: if (abort) m_ph = 0;
         else begin
           m_rem--;
           if (m_rem == 0) begin m_ph = 3; m_quiet = 0; m_age = 0; end
         end
      default: if (abort) m_ph = 0;
        else begin
          m_age++;
          m_quiet = (vd != 0) ? 0 : m_quiet + 1;
          if (m_quiet == QUIET) begin m_ph = 0; m_done = 1; end
`ifdef SYSTOLIC_ARRAY_SEQ_DRAIN_TIMEOUT_EN
          else if (m_age == TO) begin m_ph = 0; m_err = 1; end
`endif
        end
    endcase
  endtask

  task automatic step(input string nm);
    @(posedge clk);
    model_edge();
    #1;
    chk({nm, "/state"}, 32'(st), 32'(m_ph));
    chk({nm, "/busy"}, 32'(busy), 32'(m_ph != 0));
    chk({nm, "/done"}, 32'(done), 32'(m_done));
    chk({nm, "/err"}, 32'(err), 32'(m_err));
  endtask

  task automatic quiet_in();
    start = 0; abort = 0; vd = '0;
  endtask

  task automatic set_win(input int a, input int b, input int c, input int d);
    ts = AW'(a); te = AW'(b); ls = AW'(c); le = AW'(d);
  endtask

  // Count sampled cycles spent in one phase; windows scrambled meanwhile.
  task automatic count_phase(input int ph, output int n);
    n = 0;
    while (st == 4'(ph) && n < 3000) begin
      set_win($urandom, $urandom, $urandom, $urandom);
      step("dur");
      n++;
    end
  endtask

  typedef struct {
    bit         start;
    bit         abort;
    int         ts, te, ls, le;
    logic [3:0] st;
    bit         busy, err;
  } vec_t;

  vec_t vt[9];
  int   n;
  int   cm[4];
  int   cn[4];

  initial begin
    vt[0] = '{0, 0, 0, 0, 0, 0, 4'd0, 0, 0};
    vt[1] = '{1, 0, 5, 2, 0, 7, 4'd0, 0, 1};
    vt[2] = '{0, 0, 5, 2, 0, 7, 4'd0, 0, 0};
    vt[3] = '{1, 0, 0, 7, 9, 3, 4'd0, 0, 1};
    vt[4] = '{0, 1, 0, 7, 0, 7, 4'd0, 0, 0};
    vt[5] = '{1, 1, 0, 1, 0, 0, 4'd1, 1, 0};
    vt[6] = '{1, 0, 5, 2, 0, 7, 4'd1, 1, 0};
    vt[7] = '{0, 0, 0, 0, 0, 0, 4'd1, 1, 0};
    vt[8] = '{0, 1, 0, 0, 0, 0, 4'd0, 0, 0};

    // Reset with random inputs.
    model_reset();
    start = 1; abort = 1; set_win($urandom, $urandom, $urandom, $urandom);
    vd = NC'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst/state", 32'(st), 0);
    chk("rst/busy", 32'(busy), 0);
    chk("rst/done", 32'(done), 0);
    chk("rst/err", 32'(err), 0);
    quiet_in();
    rst_n = 1;
    step("post_rst");

    // Vector table.
    for (int i = 0; i < 9; i++) begin
      start = vt[i].start; abort = vt[i].abort;
      set_win(vt[i].ts, vt[i].te, vt[i].ls, vt[i].le);
      step("vec");
      chk($sformatf("vec%0d/state", i), 32'(st), 32'(vt[i].st));
      chk($sformatf("vec%0d/busy", i), 32'(busy), 32'(vt[i].busy));
      chk($sformatf("vec%0d/err", i), 32'(err), 32'(vt[i].err));
    end
    quiet_in();
    step("idle");

    // Nominal tile.
    set_win(0, 7, 0, 7); start = 1;
    step("nom_acc");
    chk("nom/acc_state", 32'(st), 1);
    start = 0;
    count_phase(1, n);
    chk("nom/warmup_len", 32'(n), 11);
    count_phase(2, n);
    chk("nom/steady_len", 32'(n), 22);
    n = 0;
    while (st == 4'd3 && n < 3000) begin
      vd = (n < 5) ? 8'hFF : 8'h00;
      step("nom_drain");
      n++;
    end
    chk("nom/drain_len", 32'(n), 9);
    chk("nom/done", 32'(done), 1);
    chk("nom/busy_fall", 32'(busy), 0);
    // Start in the o_done cycle is accepted.
    vd = '0; set_win(0, 3, 0, 3); start = 1;
    step("start_on_done");
    chk("start_on_done/state", 32'(st), 1);
    start = 0;
    count_phase(1, n);

    // Abort in the 3rd STEADY cycle.
    step("steady2");
    step("steady3");
    abort = 1;
    step("abort");
    chk("abort/state", 32'(st), 0);
    chk("abort/done", 32'(done), 0);
    chk("abort/err", 32'(err), 0);
    abort = 0; set_win(2, 4, 1, 1); start = 1;
    step("restart");
    chk("restart/state", 32'(st), 1);
    start = 0; abort = 1;
    step("cleanup");
    abort = 0;

    // Full depth, both skew settings.
    set_win(0, 1023, 0, 0); start = 1;
    step("full_acc");
    chk("full/ns_acc", 32'(ns_st), 1);
    start = 0;
    for (int k = 0; k < 4; k++) begin cm[k] = 0; cn[k] = 0; end
    for (int c = 0; c < 1100; c++) begin
      if (st < 4) cm[st]++;
      if (ns_st < 4) cn[ns_st]++;
      step("full");
    end
    chk("full/warm", 32'(cm[1]), 1027);
    chk("full/steady", 32'(cm[2]), 1 + SKEW);
    chk("full/drain", 32'(cm[3]), QUIET);
    chk("full/ns_warm", 32'(cn[1]), 1027);
    chk("full/ns_steady", 32'(cn[2]), 1);
    chk("full/ns_drain", 32'(cn[3]), QUIET);

    // Mid-tile asynchronous reset.
    set_win(0, 2, 0, 2); start = 1;
    step("mid_acc");
    start = 0;
    repeat (8) step("mid");
    rst_n = 0;
    #1;
    model_reset();
    chk("midrst/state", 32'(st), 0);
    chk("midrst/busy", 32'(busy), 0);
    #2;
    rst_n = 1;
    step("midrst_after");

    // DRAIN watchdog.
    set_win(0, 0, 0, 0); start = 1; vd = 8'h01;
    step("to_acc");
    start = 0;
    n = 0;
    while (st != 4'd3 && n < 100) begin step("to_pre"); n++; end
    chk("to/reached_drain", 32'(st), 3);
`ifdef SYSTOLIC_ARRAY_SEQ_DRAIN_TIMEOUT_EN
    n = 0;
    while (st == 4'd3 && n < 200) begin step("to_drain"); n++; end
    chk("to/drain_len", 32'(n), TO);
    chk("to/err", 32'(err), 1);
    chk("to/done", 32'(done), 0);
`else
    repeat (2000) step("to_wait");
    chk("to/still_drain", 32'(st), 3);
    abort = 1;
    step("to_abort");
    abort = 0;
`endif
    vd = '0;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 60) == 0);
      set_win($urandom_range(0, 15), $urandom_range(0, 20),
              $urandom_range(0, 15), $urandom_range(0, 20));
      vd = ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0;
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
